// File: rtl/sd_twopiece_pkg.sv
// Shared constants and types for the two-piece sigma-delta sinusoid source.
package sd_twopiece_pkg;

    localparam int unsigned KIN_W    = 28;
    localparam int unsigned KIN_FRAC = 28;

    typedef logic [1:0] sd_bus_t;

    // Modulator full scale: 2^(bitwidth-1)
    function automatic logic [63:0] sd_full_scale(input int unsigned bitwidth);
        return 64'd1 << (bitwidth - 1);
    endfunction

endpackage

// File: rtl/sigma_delta_two_piece_piece.sv
// One oscillator piece: signed state register, kin-scaled "gained" term and a
// first-order 1-bit sigma-delta modulator driven by the pre-update state.
module sd_piece
    import sd_twopiece_pkg::*;
#(
    parameter int unsigned                BITWIDTH       = 40,
    parameter logic signed [BITWIDTH-1:0] RESET_VAL      = '0,
    parameter bit                         GAIN_FROM_NEXT = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [KIN_W-1:0]           kin,
    input  logic signed [BITWIDTH-1:0] incr,
    output logic signed [BITWIDTH-1:0] gained,
    output logic                       y
);

    localparam logic signed [BITWIDTH+1:0] FS = (BITWIDTH+2)'(sd_full_scale(BITWIDTH));

    logic signed [BITWIDTH-1:0]       state;
    logic signed [BITWIDTH-1:0]       state_next;
    logic signed [BITWIDTH-1:0]       gain_src;
    logic signed [BITWIDTH+KIN_W:0]   src_ext;
    logic signed [BITWIDTH+KIN_W:0]   kin_ext;
    logic signed [BITWIDTH+1:0]       acc;
    logic signed [BITWIDTH+1:0]       acc_next;

    // The cosine piece scales its freshly updated value so the sine piece
    // sees gained(c_next) within the same cycle (magic-circle ordering).
    always_comb begin
        state_next = state + incr;
        gain_src   = GAIN_FROM_NEXT ? state_next : state;
        src_ext    = $signed({{(KIN_W+1){gain_src[BITWIDTH-1]}}, gain_src});
        kin_ext    = $signed({{BITWIDTH{1'b0}}, 1'b0, kin});
        gained     = BITWIDTH'((src_ext * kin_ext) >>> KIN_FRAC);
        acc_next   = acc + $signed({{2{state[BITWIDTH-1]}}, state}) - (y ? FS : -FS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RESET_VAL;
            acc   <= '0;
            y     <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            y     <= ~acc_next[BITWIDTH+1];
        end
    end

endmodule

// File: rtl/sigma_delta_two_piece.sv
// Coupled-form sinusoid source with cosine/sine 1-bit sigma-delta outputs.
// Define SD_TWOPIECE_REG_OUT_EN to add one registered stage on sd_out.
module sigma_delta_two_piece
    import sd_twopiece_pkg::*;
#(
    parameter int          FSIG     = 1000,
    parameter int unsigned BITWIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KIN_W-1:0] kin,
    output logic [1:0]       sd_out
);

    localparam logic signed [BITWIDTH-1:0] C_RESET = BITWIDTH'(FSIG) << (BITWIDTH - 16);

    logic signed [BITWIDTH-1:0] gained_c;
    logic signed [BITWIDTH-1:0] gained_s;
    logic signed [BITWIDTH-1:0] c_incr;
    sd_bus_t                    y_bus;

    assign c_incr = -gained_s;

    sd_piece #(
        .BITWIDTH       (BITWIDTH),
        .RESET_VAL      (C_RESET),
        .GAIN_FROM_NEXT (1'b1)
    ) piece_0 (
        .clk    (clk),
        .reset  (reset),
        .kin    (kin),
        .incr   (c_incr),
        .gained (gained_c),
        .y      (y_bus[0])
    );

    sd_piece #(
        .BITWIDTH       (BITWIDTH),
        .RESET_VAL      ('0),
        .GAIN_FROM_NEXT (1'b0)
    ) piece_1 (
        .clk    (clk),
        .reset  (reset),
        .kin    (kin),
        .incr   (gained_c),
        .gained (gained_s),
        .y      (y_bus[1])
    );

`ifdef SD_TWOPIECE_REG_OUT_EN
    sd_bus_t sd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sd_q <= '0;
        end else begin
            sd_q <= y_bus;
        end
    end

    assign sd_out = sd_q;
`else
    assign sd_out = y_bus;
`endif

endmodule

// File: tb/tb_sigma_delta_two_piece.sv
// Directed bench for sigma_delta_two_piece (FSIG=1000, BITWIDTH=40).
module tb_sigma_delta_two_piece;

    localparam int unsigned BW = 40;
    localparam longint      C0 = longint'(1000) <<< 24;
    localparam longint      FS = longint'(1) <<< 39;
    localparam logic [27:0] K1 = 28'he2b9946;
    localparam logic [27:0] K2 = 28'h0400000;
`ifdef SD_TWOPIECE_REG_OUT_EN
    localparam bit          REG_OUT = 1'b1;
    localparam logic [1:0]  SEQ [6] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00};
`else
    localparam bit          REG_OUT = 1'b0;
    localparam logic [1:0]  SEQ [6] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11};
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [27:0] kin;
    logic [1:0]  sd_out;

    always #5 clk = ~clk;

    sigma_delta_two_piece #(
        .FSIG     (1000),
        .BITWIDTH (BW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .kin    (kin),
        .sd_out (sd_out)
    );

    int         total  = 0;
    int         passed = 0;
    longint     mc, ms, macc0, macc1;
    bit         my0, my1;
    logic [1:0] exp_sd, sd_pipe;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
        total++;
        assert (obs >= lo && obs <= hi) passed++;
        else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    endtask

    function automatic longint t40(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    function automatic longint gain(input longint x, input longint k);
        return t40((x * k) >>> 28);
    endfunction

    function automatic longint dut_c();
        return longint'(dut.piece_0.state);
    endfunction

    function automatic longint dut_s();
        return longint'(dut.piece_1.state);
    endfunction

    task automatic model_reset();
        mc = C0; ms = 0; macc0 = 0; macc1 = 0;
        my0 = 1'b0; my1 = 1'b0; sd_pipe = 2'b00; exp_sd = 2'b00;
    endtask

    task automatic model_step(input longint k);
        longint cn;
        macc0 = macc0 + mc - (my0 ? FS : -FS);
        macc1 = macc1 + ms - (my1 ? FS : -FS);
        my0 = (macc0 >= 0);
        my1 = (macc1 >= 0);
        cn = t40(mc - gain(ms, k));
        ms = t40(ms + gain(cn, k));
        mc = cn;
        if (REG_OUT) begin
            exp_sd  = sd_pipe;
            sd_pipe = {my1, my0};
        end else begin
            exp_sd = {my1, my0};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int     ones, sc, bad_sd;
        longint c, prev, pk, pk_late;
        real    kr, amp, cs, ss;

        reset = 1'b0;
        kin   = '0;
        model_reset();
        #12;
        chk("rst_sd", longint'(sd_out), 0);
        chk("rst_c", dut_c(), C0);
        chk("rst_s", dut_s(), 0);
        #8 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("seq_%0d", i), longint'(sd_out), longint'(SEQ[i]));
        end
        chk("c_frozen", dut_c(), C0);
        chk("s_frozen", dut_s(), 0);

        // 4096 * (1 + 1000/32768) / 2 = 2110.5 ones
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            ones += int'(sd_out[0]);
        end
        chk_rng("density0", longint'(ones), 2108, 2113);

        // Oscillation at k ~ 0.8856: period ~6.849 cycles
        reset = 1'b0;
        kin   = K1;
        model_reset();
        #4 reset = 1'b1;
        sc = 0; bad_sd = 0; pk = 0; pk_late = 0; prev = C0;
        for (int n = 1; n <= 20000; n++) begin
            tick();
            model_step(longint'(K1));
            c = dut_c();
            if (n <= 6850 && ((c < 0) != (prev < 0))) sc++;
            prev = c;
            if ((c < 0 ? -c : c) > pk) pk = (c < 0 ? -c : c);
            if (n > 18000 && (c < 0 ? -c : c) > pk_late) pk_late = (c < 0 ? -c : c);
            if (sd_out !== exp_sd) bad_sd++;
            if (n <= 3 || n == 20000) begin
                chk($sformatf("osc_c_%0d", n), c, mc);
                chk($sformatf("osc_s_%0d", n), dut_s(), ms);
            end
        end
        chk_rng("period_k1", longint'(sc), 1995, 2005);
        chk("sd_model_k1", longint'(bad_sd), 0);
        kr  = real'(K1) / 268435456.0;
        amp = real'(C0) / $sqrt(1.0 - kr * kr / 4.0);
        chk_rng("peak_k1", longint'($rtoi(real'(pk) * 1000.0 / amp)), 980, 1020);
        chk_rng("peak_k1_late", longint'($rtoi(real'(pk_late) * 1000.0 / amp)), 980, 1020);

        // Switch to k = 1/64: period ~402.1 cycles, ellipse set by state at switch
        cs  = real'(mc);
        ss  = real'(ms);
        kin = K2;
        kr  = real'(K2) / 268435456.0;
        amp = $sqrt((cs * cs + ss * ss - kr * cs * ss) / (1.0 - kr * kr / 4.0));
        sc = 0; bad_sd = 0; pk = 0; prev = mc;
        for (int n = 1; n <= 4100; n++) begin
            tick();
            model_step(longint'(K2));
            c = dut_c();
            if ((c < 0) != (prev < 0)) sc++;
            prev = c;
            if ((c < 0 ? -c : c) > pk) pk = (c < 0 ? -c : c);
            if (sd_out !== exp_sd) bad_sd++;
            if (n <= 2) begin
                chk($sformatf("switch_c_%0d", n), c, mc);
                chk($sformatf("switch_s_%0d", n), dut_s(), ms);
            end
        end
        chk_rng("period_k2", longint'(sc), 19, 21);
        chk("sd_model_k2", longint'(bad_sd), 0);
        chk_rng("peak_k2", longint'($rtoi(real'(pk) * 1000.0 / amp)), 980, 1020);

        // Asynchronous reset between edges
        #3 reset = 1'b0;
        kin = '0;
        model_reset();
        #1;
        chk("async_sd", longint'(sd_out), 0);
        chk("async_c", dut_c(), C0);
        chk("async_s", dut_s(), 0);
        #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rst2_seq_%0d", i), longint'(sd_out), longint'(SEQ[i]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
